// File: rtl/encoder8to3_queue.sv
// Sticky 8-request collector emitting one 3-bit index per valid/ready handshake in fixed priority.
// Latency: request to out_valid is 2 edges; back-to-back emission with ready held high.
module encoder8to3_queue #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] in_i,
  output logic [2:0] out_o,
  output logic       out_valid_o,
  input  logic       ready_i,
  output logic [7:0] pending_o,
  output logic       busy_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] out_q, out_d;
  logic [2:0] sel_idx;
  logic       load;
  logic [7:0] clr_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      pending_q <= 8'h00;
      out_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  // Selection looks only at the registered pending set; later loop iterations win.
  always_comb begin
    sel_idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end
  end

  always_comb begin
    load      = ((state_q == EMPTY) || ready_i) && (pending_q != 8'h00);
    clr_mask  = load ? (8'b0000_0001 << sel_idx) : 8'h00;
    // A new request on the bit being loaded survives the clear: it is a fresh request.
    pending_d = (pending_q & ~clr_mask) | (en_i ? in_i : 8'h00);
    out_d     = load ? sel_idx : out_q;
    state_d   = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (ready_i) state_d = load ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_o       = out_q;
    out_valid_o = (state_q == FULL);
    pending_o   = pending_q;
    busy_o      = (pending_q != 8'h00) || (state_q == FULL);
  end

endmodule
